mem_arb_ctrl: RTL

Two-requester arbiter and sequencer for the team's small read/write register memory (4 words × 4 bits by default). Each requester issues single-word read or write requests over a valid/ready handshake. The block grants one request at a time, performs the access on a clocked storage array, and returns a response per requester. It sits between the CPU-side and DMA-side request ports and the memory, so that the memory is no longer written combinationally by its consumers.

---
 rtl/mem_arb_ctrl_pkg.sv | 31 +++
 rtl/mem_arb_ctrl_if.sv | 36 +++
 rtl/mem_rw_array_sync.sv | 54 +++++
 rtl/mem_arb_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_arb_ctrl_pkg.sv
//==============================================================================
// Package : mem_arb_pkg
// Shared widths, FSM state type, requester id and storage reset image.
// Revision: 1.0
//==============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef logic req_id_t;

   localparam logic [3:0] MEM_RST_WORDS [4] = '{4'hE, 4'h2, 4'hF, 4'h4};

   // Words beyond the fixed image come up as zero.
   function automatic logic [3:0] rst_word(input int idx);
      if (idx >= 0 && idx < 4) return MEM_RST_WORDS[idx[1:0]];
      return 4'h0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_ctrl_if.sv
//==============================================================================
// Interface : mem_arb_ctrl_if
// Two-requester request/response bus between requesters and mem_arb_ctrl.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface mem_arb_ctrl_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          resp_valid;
   logic [1:0]          resp_ready;
   logic [DATA_W-1:0]   resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

`default_nettype wire

// File: rtl/mem_rw_array_sync.sv
//==============================================================================
// Module : mem_rw_array_sync
// Clocked storage array with reset image and registered read/ack data.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_rw_array_sync
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] words [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(rst_word(gi));
      logic [DATA_W-1:0] word_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            word_q <= RST_VAL;
         else if (en_i && we_i && (addr_i == ADDR_W'(gi)))
            word_q <= wdata_i;
      end

      assign words[gi] = word_q;
   end

   // A write echoes its own data so the ack carries the committed value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rdata_q <= '0;
      else if (en_i)
         rdata_q <= we_i ? wdata_i : words[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_arb_ctrl.sv
//==============================================================================
// Module : mem_arb_ctrl
// Two-requester arbiter and single-transaction sequencer for the register memory.
// Build option: define MEM_ARB_RR_EN for round-robin, otherwise fixed R0 priority.
// Revision: 1.0
//==============================================================================
`default_nettype none

module mem_arb_ctrl
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arb_ctrl_if.slave bus
);

   arb_state_e        state_q, state_d;
   req_id_t           grant_id;
   req_id_t           id_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              handshake;
   logic              mem_en;

   assign handshake = (state_q == IDLE) && (|bus.req_valid);

`ifdef MEM_ARB_RR_EN
   // Holds the last winner; reset to R1 so R0 takes the first tie.
   req_id_t last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= 1'b1;
      else if (handshake)
         last_q <= grant_id;
   end

   always_comb begin
      if (bus.req_valid == 2'b11)
         grant_id = ~last_q;
      else
         grant_id = ~bus.req_valid[0];
   end
`else
   always_comb begin
      grant_id = ~bus.req_valid[0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (handshake) begin
         id_q    <= grant_id;
         we_q    <= bus.req_we[grant_id];
         addr_q  <= grant_id ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
         wdata_q <= grant_id ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|bus.req_valid) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    if (bus.resp_ready[id_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = 2'b00;
      bus.resp_valid = 2'b00;
      mem_en         = 1'b0;
      unique case (state_q)
         IDLE:    if (|bus.req_valid) bus.req_ready[grant_id] = 1'b1;
         ACCESS:  mem_en = 1'b1;
         RESP:    bus.resp_valid[id_q] = 1'b1;
         default: ;
      endcase
   end

   mem_rw_array_sync #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (mem_en),
      .we_i    (we_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (bus.resp_rdata)
   );

endmodule

`default_nettype wire
